// File: rtl/ddr_pkg.sv
// Shared DDR controller definitions: CAS request codes, the CAS scheduler
// state type, and the read/write turnaround window used by several blocks.
package ddr_pkg;

    localparam int unsigned TW_W = 16;

    // Bit 2 of a request code marks a write.
    typedef enum logic [2:0] {
        RD_R  = 3'b001,
        RDA_R = 3'b011,
        WR_R  = 3'b101,
        WRA_R = 3'b111
    } cas_code_e;

    typedef enum logic [1:0] {
        CAS_IDLE = 2'd0,
        CAS_WAIT = 2'd1,
        CAS_CMD  = 2'd2
    } cas_sched_fsm_type;

    function automatic logic is_write(input logic [2:0] code);
        return code[2];
    endfunction

    // Spacing needed when the bus turns around; results below 1 clamp to 1.
    function automatic logic [TW_W+1:0] turn_window(
        input logic            rd_to_wr,
        input logic            same_bg,
        input logic [TW_W-1:0] cl,
        input logic [TW_W-1:0] cwl,
        input logic [TW_W-1:0] al,
        input logic [TW_W-1:0] bl,
        input logic [TW_W-1:0] twtr_s,
        input logic [TW_W-1:0] twtr_l
    );
        logic signed [TW_W+1:0] w;
        logic        [TW_W+1:0] half_bl;
        half_bl = {3'b000, bl[TW_W-1:1]};
        if (rd_to_wr) begin
            w = $signed({2'b00, cl} - {2'b00, al} - {2'b00, cwl} + half_bl
                        + (TW_W+2)'(2));
        end else begin
            w = $signed({2'b00, cwl} + half_bl
                        + {2'b00, (same_bg ? twtr_l : twtr_s)});
        end
        if (w[TW_W+1] || (w == '0)) begin
            return (TW_W+2)'(1);
        end
        return w;
    endfunction

endpackage

// File: rtl/cas_req_fifo.sv
// In-order request FIFO; exposes head, the entry behind it and both pointers
// so the owner can keep per-slot side state alongside the entries.
module cas_req_fifo
    import ddr_pkg::*;
#(
    parameter  int unsigned DEPTH = 8,
    parameter  int unsigned W     = 5,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [W-1:0]  wdata_i,
    output logic [W-1:0]  head_o,
    output logic [W-1:0]  next_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [AW:0]   cnt_o,
    output logic [AW-1:0] rd_ptr_o,
    output logic [AW-1:0] wr_ptr_o
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          do_push, do_pop;

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_pop  = pop_i && (cnt_q != '0);
    assign do_push = push_i && ((cnt_q != FULL_CNT) || do_pop);

    always_comb begin
        rd_d  = rd_q;
        wr_d  = wr_q;
        cnt_d = cnt_q;
        if (do_pop)  rd_d = rd_q + AW'(1);
        if (do_push) wr_d = wr_q + AW'(1);
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + (AW+1)'(1);
            2'b01:   cnt_d = cnt_q - (AW+1)'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_q] <= wdata_i;
    end

    assign head_o   = mem_q[rd_q];
    assign next_o   = mem_q[rd_q + AW'(1)];
    assign full_o   = (cnt_q == FULL_CNT);
    assign empty_o  = (cnt_q == '0);
    assign cnt_o    = cnt_q;
    assign rd_ptr_o = rd_q;
    assign wr_ptr_o = wr_q;

endmodule

// File: rtl/ctrl_cas_sched.sv
// CAS scheduler: queues requests behind their ACT, waits out tRCD per entry,
// and spaces CAS commands by the CCD window and read/write turnaround.
module ctrl_cas_sched
    import ddr_pkg::*;
#(
    parameter  int unsigned DEPTH  = 8,
    parameter  int unsigned NUM_BG = 4,
    parameter  int unsigned CNT_W  = 8,
    localparam int unsigned BG_W   = $clog2(NUM_BG)
) (
    input  logic             CK_t,
    input  logic             reset_n,
    input  logic             act_rdy,
    input  logic [2:0]       act_rw,
    input  logic [BG_W-1:0]  act_bg,
    input  logic [CNT_W-1:0] tRCD,
    input  logic [CNT_W-1:0] tCCD_S,
    input  logic [CNT_W-1:0] tCCD_L,
    input  logic [CNT_W-1:0] tWTR_S,
    input  logic [CNT_W-1:0] tWTR_L,
    input  logic [CNT_W-1:0] CL,
    input  logic [CNT_W-1:0] CWL,
    input  logic [CNT_W-1:0] AL,
    input  logic [CNT_W-1:0] BL,
    output logic             cas_rdy,
    output logic [2:0]       cas_req,
    output logic [BG_W-1:0]  cas_bg,
    output logic             cas_idle,
    output logic             q_full,
    output logic             overflow
);

    localparam int unsigned    AW      = $clog2(DEPTH);
    localparam int unsigned    EW      = 3 + BG_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    function automatic logic [CNT_W-1:0] dec_sat(input logic [CNT_W-1:0] v);
        return (v == '0) ? '0 : v - CNT_W'(1);
    endfunction

    function automatic logic [CNT_W-1:0] sat_cnt(input logic [TW_W+1:0] v);
        if (v > (TW_W+2)'(CNT_MAX)) return CNT_MAX;
        return v[CNT_W-1:0];
    endfunction

    cas_sched_fsm_type state_q, state_d;

    logic [CNT_W-1:0] rcd_q [DEPTH];
    logic [CNT_W-1:0] rcd_d [DEPTH];
    logic [CNT_W-1:0] gap_q, gap_d, turn_q, turn_d;
    logic [2:0]       cas_req_q, cas_req_d;
    logic [BG_W-1:0]  cas_bg_q, cas_bg_d;
    logic             last_wr_q, last_wr_d;
    logic [BG_W-1:0]  last_bg_q, last_bg_d;
    logic             last_vld_q, last_vld_d;
    logic             pend_q, pend_d;
    logic             ovf_q, ovf_d;

    logic [EW-1:0]    head, nxt;
    logic [2:0]       head_code, nxt_code, cand_code;
    logic [BG_W-1:0]  head_bg, nxt_bg, cand_bg, ref_bg;
    logic             ref_wr, dir_chg;
    logic             full, empty, push_ok, pop, eligible, multi;
    logic [AW:0]      cnt;
    logic [AW-1:0]    rd_ptr, wr_ptr;
    logic [TW_W+1:0]  win;
    logic [CNT_W-1:0] turn_load;

    cas_req_fifo #(
        .DEPTH (DEPTH),
        .W     (EW)
    ) u_fifo (
        .clk_i    (CK_t),
        .rst_ni   (reset_n),
        .push_i   (act_rdy),
        .pop_i    (pop),
        .wdata_i  ({act_rw, act_bg}),
        .head_o   (head),
        .next_o   (nxt),
        .full_o   (full),
        .empty_o  (empty),
        .cnt_o    (cnt),
        .rd_ptr_o (rd_ptr),
        .wr_ptr_o (wr_ptr)
    );

    assign head_code = head[EW-1 -: 3];
    assign head_bg   = head[BG_W-1:0];
    assign nxt_code  = nxt[EW-1 -: 3];
    assign nxt_bg    = nxt[BG_W-1:0];
    assign multi     = (cnt != (AW+1)'(1));
    assign push_ok   = act_rdy && (!full || pop);

    // A pending turnaround check blocks issue until the late head is classified.
    assign eligible = !empty && (rcd_q[rd_ptr] == '0) && (gap_q == '0)
                      && (turn_q == '0) && !pend_q;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) rcd_d[i] = dec_sat(rcd_q[i]);
        if (push_ok) rcd_d[wr_ptr] = dec_sat(tRCD);
    end

    always_comb begin
        state_d    = state_q;
        pop        = 1'b0;
        gap_d      = dec_sat(gap_q);
        turn_d     = dec_sat(turn_q);
        cas_req_d  = cas_req_q;
        cas_bg_d   = cas_bg_q;
        last_wr_d  = last_wr_q;
        last_bg_d  = last_bg_q;
        last_vld_d = last_vld_q;
        pend_d     = pend_q;
        ovf_d      = ovf_q;

        case (state_q)
            CAS_IDLE: begin
                last_vld_d = 1'b0;
                pend_d     = 1'b0;
                if (act_rdy) state_d = CAS_WAIT;
            end
            CAS_WAIT: begin
                if (eligible) begin
                    state_d = CAS_CMD;
                    pop     = 1'b1;
                end
            end
            CAS_CMD: begin
                state_d = (!empty || act_rdy) ? CAS_WAIT : CAS_IDLE;
            end
            default: state_d = CAS_IDLE;
        endcase

        if (act_rdy && full && !pop) ovf_d = 1'b1;

        // At a pop the entry behind the head is compared with the head itself;
        // otherwise a late-arriving head is compared with the last issued CAS.
        cand_code = pop ? nxt_code : head_code;
        cand_bg   = pop ? nxt_bg : head_bg;
        ref_wr    = pop ? is_write(head_code) : last_wr_q;
        ref_bg    = pop ? head_bg : last_bg_q;
        dir_chg   = (is_write(cand_code) != ref_wr);
        win       = turn_window(!ref_wr, (cand_bg == ref_bg),
                                TW_W'(CL), TW_W'(CWL), TW_W'(AL), TW_W'(BL),
                                TW_W'(tWTR_S), TW_W'(tWTR_L));
        turn_load = sat_cnt(win - (TW_W+2)'(1));

        if (pop) begin
            cas_req_d  = head_code;
            cas_bg_d   = head_bg;
            last_wr_d  = is_write(head_code);
            last_bg_d  = head_bg;
            last_vld_d = 1'b1;
            gap_d      = dec_sat((!multi || (nxt_bg == head_bg)) ? tCCD_L : tCCD_S);
            pend_d     = !multi;
            if (multi && dir_chg) turn_d = turn_load;
        end else if (pend_q && !empty && (state_q != CAS_IDLE)) begin
            pend_d = 1'b0;
            if (last_vld_q && dir_chg) turn_d = turn_load;
        end
    end

    always_ff @(posedge CK_t or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= CAS_IDLE;
            gap_q      <= '0;
            turn_q     <= '0;
            cas_req_q  <= '0;
            cas_bg_q   <= '0;
            last_wr_q  <= 1'b0;
            last_bg_q  <= '0;
            last_vld_q <= 1'b0;
            pend_q     <= 1'b0;
            ovf_q      <= 1'b0;
            for (int i = 0; i < DEPTH; i++) rcd_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            gap_q      <= gap_d;
            turn_q     <= turn_d;
            cas_req_q  <= cas_req_d;
            cas_bg_q   <= cas_bg_d;
            last_wr_q  <= last_wr_d;
            last_bg_q  <= last_bg_d;
            last_vld_q <= last_vld_d;
            pend_q     <= pend_d;
            ovf_q      <= ovf_d;
            for (int i = 0; i < DEPTH; i++) rcd_q[i] <= rcd_d[i];
        end
    end

    assign cas_rdy  = (state_q == CAS_CMD);
    assign cas_req  = cas_req_q;
    assign cas_bg   = cas_bg_q;
    assign cas_idle = (state_q == CAS_IDLE) && empty;
    assign q_full   = full;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_ctrl_cas_sched.sv
// Directed scoreboard bench for ctrl_cas_sched: expected CAS commands are
// queued as requests are driven and matched as cas_rdy pulses appear.
module tb_ctrl_cas_sched;
    import ddr_pkg::*;

    logic       CK_t, reset_n, act_rdy;
    logic [2:0] act_rw;
    logic [1:0] act_bg;
    logic [7:0] tRCD, tCCD_S, tCCD_L, tWTR_S, tWTR_L, CL, CWL, AL, BL;
    logic       cas_rdy, cas_idle, q_full, overflow;
    logic [2:0] cas_req;
    logic [1:0] cas_bg;

    typedef struct {
        logic [2:0] code;
        logic [1:0] bg;
        int         cyc;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   cyc   = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_cas = 0;

    ctrl_cas_sched dut (
        .CK_t     (CK_t),
        .reset_n  (reset_n),
        .act_rdy  (act_rdy),
        .act_rw   (act_rw),
        .act_bg   (act_bg),
        .tRCD     (tRCD),
        .tCCD_S   (tCCD_S),
        .tCCD_L   (tCCD_L),
        .tWTR_S   (tWTR_S),
        .tWTR_L   (tWTR_L),
        .CL       (CL),
        .CWL      (CWL),
        .AL       (AL),
        .BL       (BL),
        .cas_rdy  (cas_rdy),
        .cas_req  (cas_req),
        .cas_bg   (cas_bg),
        .cas_idle (cas_idle),
        .q_full   (q_full),
        .overflow (overflow)
    );

    initial CK_t = 1'b0;
    always #5 CK_t = ~CK_t;
    always @(posedge CK_t) cyc <= cyc + 1;

    always @(negedge CK_t) begin
        if (cas_rdy === 1'b1) begin
            n_cas++;
            if (exp_q.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL unexpected_cas cyc=%0d req=%0d bg=%0d want none", cyc, cas_req, cas_bg);
            end else begin
                mon_e = exp_q.pop_front();
                n_cmp++;
                if (cas_req !== mon_e.code) begin
                    n_bad++;
                    $display("FAIL cas_req got=%0d want=%0d", cas_req, mon_e.code);
                end
                n_cmp++;
                if (cas_bg !== mon_e.bg) begin
                    n_bad++;
                    $display("FAIL cas_bg got=%0d want=%0d", cas_bg, mon_e.bg);
                end
                n_cmp++;
                if (cyc !== mon_e.cyc) begin
                    n_bad++;
                    $display("FAIL cas_cycle got=%0d want=%0d", cyc, mon_e.cyc);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog cyc=%0d want finish", cyc);
        $fatal(1, "timeout");
    end

    task automatic set_timing();
        tRCD = 8'd4;  tCCD_S = 8'd4; tCCD_L = 8'd6; tWTR_S = 8'd3; tWTR_L = 8'd8;
        CL   = 8'd16; CWL    = 8'd12; AL    = 8'd0; BL     = 8'd8;
    endtask

    // Called at a negedge; the request is sampled at the next rising edge.
    task automatic drive_push(input logic [2:0] code, input logic [1:0] bg, output int at);
        act_rdy = 1'b1; act_rw = code; act_bg = bg;
        at = cyc + 1;
        @(negedge CK_t);
    endtask

    task automatic end_push();
        act_rdy = 1'b0;
    endtask

    task automatic expect_cas(input logic [2:0] code, input logic [1:0] bg, input int c);
        exp_t e;
        e.code = code; e.bg = bg; e.cyc = c;
        exp_q.push_back(e);
    endtask

    task automatic drain(input int budget, output int left);
        int k = 0;
        while ((exp_q.size() != 0 || cas_idle !== 1'b1) && k < budget) begin
            @(negedge CK_t);
            k++;
        end
        left = exp_q.size();
        exp_q.delete();
        repeat (30) @(negedge CK_t);
    endtask

    task automatic test_reset();
        n_cmp++; if (cas_rdy !== 1'b0)  begin n_bad++; $display("FAIL rst_cas_rdy got=%b want=0", cas_rdy); end
        n_cmp++; if (cas_req !== 3'd0)  begin n_bad++; $display("FAIL rst_cas_req got=%0d want=0", cas_req); end
        n_cmp++; if (cas_bg !== 2'd0)   begin n_bad++; $display("FAIL rst_cas_bg got=%0d want=0", cas_bg); end
        n_cmp++; if (cas_idle !== 1'b1) begin n_bad++; $display("FAIL rst_cas_idle got=%b want=1", cas_idle); end
        n_cmp++; if (q_full !== 1'b0)   begin n_bad++; $display("FAIL rst_q_full got=%b want=0", q_full); end
        n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL rst_overflow got=%b want=0", overflow); end
    endtask

    task automatic test_latency();
        int a, left;
        set_timing(); tRCD = 8'd14;
        while (cyc < 9) @(negedge CK_t);
        drive_push(RD_R, 2'd0, a);
        end_push();
        expect_cas(RD_R, 2'd0, 24);
        n_cmp++; if (a !== 10) begin n_bad++; $display("FAIL lat_push_cycle got=%0d want=10", a); end
        while (cyc < 24) @(negedge CK_t);
        n_cmp++; if (cas_idle !== 1'b0) begin n_bad++; $display("FAIL lat_idle24 got=%b want=0", cas_idle); end
        @(negedge CK_t);
        n_cmp++; if (cas_idle !== 1'b1) begin n_bad++; $display("FAIL lat_idle25 got=%b want=1", cas_idle); end
        drain(100, left);
        n_cmp++; if (left !== 0) begin n_bad++; $display("FAIL lat_drain left=%0d want=0", left); end
    endtask

    task automatic test_ccd(input logic [1:0] bg2, input int gap);
        int a0, a1, left;
        set_timing();
        drive_push(RD_R, 2'd0, a0);
        drive_push(RD_R, bg2, a1);
        end_push();
        expect_cas(RD_R, 2'd0, a0 + 4);
        expect_cas(RD_R, bg2, a0 + 4 + gap);
        drain(100, left);
        n_cmp++; if (left !== 0) begin n_bad++; $display("FAIL ccd_drain gap=%0d left=%0d want=0", gap, left); end
    endtask

    task automatic test_turn(input logic [2:0] c1, input logic [2:0] c2,
                             input logic [1:0] bg2, input int gap);
        int a0, a1, left;
        set_timing();
        drive_push(c1, 2'd0, a0);
        drive_push(c2, bg2, a1);
        end_push();
        expect_cas(c1, 2'd0, a0 + 4);
        expect_cas(c2, bg2, a0 + 4 + gap);
        drain(150, left);
        n_cmp++; if (left !== 0) begin n_bad++; $display("FAIL turn_drain gap=%0d left=%0d want=0", gap, left); end
    endtask

    task automatic test_min_rcd(input logic [7:0] rcd);
        int a, left;
        set_timing(); tRCD = rcd;
        drive_push(WRA_R, 2'd2, a);
        end_push();
        expect_cas(WRA_R, 2'd2, a + 1);
        drain(50, left);
        n_cmp++; if (left !== 0) begin n_bad++; $display("FAIL min_rcd_drain rcd=%0d left=%0d want=0", rcd, left); end
    endtask

    task automatic test_back_to_back();
        int a0, a, left;
        set_timing(); tRCD = 8'd20;
        for (int i = 0; i < 9; i++) begin
            logic [1:0] bg;
            bg = 2'(i % 2);
            drive_push(RD_R, bg, a);
            if (i == 0) a0 = a;
            if (i < 8) expect_cas(RD_R, bg, a0 + 20 + 4 * i);
            if (i == 7) begin
                n_cmp++; if (q_full !== 1'b1)   begin n_bad++; $display("FAIL b2b_full8 got=%b want=1", q_full); end
                n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL b2b_ovf8 got=%b want=0", overflow); end
            end
        end
        end_push();
        n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL b2b_ovf9 got=%b want=1", overflow); end
        n_cmp++; if (q_full !== 1'b1)   begin n_bad++; $display("FAIL b2b_full9 got=%b want=1", q_full); end
        drain(200, left);
        n_cmp++; if (left !== 0)        begin n_bad++; $display("FAIL b2b_drain left=%0d want=0", left); end
        n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL b2b_sticky got=%b want=1", overflow); end
        n_cmp++; if (q_full !== 1'b0)   begin n_bad++; $display("FAIL b2b_full_end got=%b want=0", q_full); end
    endtask

    task automatic test_reset_midop();
        int a, cas_before, left;
        set_timing(); tRCD = 8'd20;
        drive_push(RD_R, 2'd0, a);
        drive_push(WR_R, 2'd1, a);
        drive_push(RDA_R, 2'd2, a);
        end_push();
        repeat (3) @(negedge CK_t);
        reset_n = 1'b0;
        #1;
        n_cmp++; if (cas_idle !== 1'b1) begin n_bad++; $display("FAIL midrst_idle got=%b want=1", cas_idle); end
        n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL midrst_ovf got=%b want=0", overflow); end
        n_cmp++; if (cas_rdy !== 1'b0)  begin n_bad++; $display("FAIL midrst_cas_rdy got=%b want=0", cas_rdy); end
        repeat (2) @(negedge CK_t);
        reset_n = 1'b1;
        cas_before = n_cas;
        repeat (40) @(negedge CK_t);
        n_cmp++; if (n_cas !== cas_before) begin n_bad++; $display("FAIL midrst_no_cas got=%0d want=%0d", n_cas, cas_before); end
        n_cmp++; if (cas_idle !== 1'b1)     begin n_bad++; $display("FAIL midrst_idle_after got=%b want=1", cas_idle); end
        tRCD = 8'd4;
        drive_push(WR_R, 2'd3, a);
        end_push();
        expect_cas(WR_R, 2'd3, a + 4);
        drain(50, left);
        n_cmp++; if (left !== 0) begin n_bad++; $display("FAIL midrst_drain left=%0d want=0", left); end
    endtask

    initial begin
        reset_n = 1'b0; act_rdy = 1'b0; act_rw = 3'd0; act_bg = 2'd0;
        set_timing();
        repeat (2) @(negedge CK_t);
        test_reset();
        reset_n = 1'b1;
        test_latency();
        test_ccd(2'd1, 4);
        test_ccd(2'd0, 6);
        test_turn(RD_R, WR_R, 2'd0, 10);
        test_turn(WR_R, RD_R, 2'd0, 24);
        test_turn(WR_R, RD_R, 2'd1, 19);
        test_min_rcd(8'd0);
        test_min_rcd(8'd1);
        test_back_to_back();
        test_reset_midop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ctrl_cas_sched.md
CTRL_CAS_SCHED -- requirements
Module: ctrl_cas_sched

Interface
REQ-001 SHALL have parameter DEPTH, default 8, pending-CAS queue entries (power of 2, >=2).
REQ-002 SHALL have parameter NUM_BG, default 4, bank-group count; BG_W = clog2(NUM_BG).
REQ-003 SHALL have parameter CNT_W, default 8, width of every timing input and internal counter.
REQ-004 Ports (name  direction  width  meaning):
- CK_t  in  1  clock; all state updates on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- act_rdy  in  1  push strobe: an ACT or no-ACT command was issued for this request.
- act_rw  in  3  request code: RD_R, RDA_R, WR_R or WRA_R.
- act_bg  in  BG_W  bank group of the request.
- tRCD, tCCD_S, tCCD_L, tWTR_S, tWTR_L, CL, CWL, AL, BL  in  CNT_W each  timing values, static while the queue is non-empty.
- cas_rdy  out  1  one-cycle CAS issue pulse.
- cas_req  out  3  code of the issued CAS; valid while cas_rdy is high.
- cas_bg  out  BG_W  bank group of the issued CAS; valid while cas_rdy is high.
- cas_idle  out  1  high when the queue is empty and state is CAS_IDLE.
- q_full  out  1  queue holds DEPTH entries.
- overflow  out  1  sticky; set when a push is dropped.

Function
REQ-005 On an act_rdy cycle the block SHALL push {act_rw, act_bg, rcd=tRCD-1} into an in-order FIFO. If the FIFO is full and no pop occurs in the same cycle, it SHALL drop the push and set overflow.
REQ-006 Each cycle, every entry's rcd SHALL decrement, saturating at 0.
REQ-007 The FSM SHALL have three states.
- CAS_IDLE: entered when the queue is empty; goes to CAS_WAIT on a push.
- CAS_WAIT: holds while the head is not eligible.
- CAS_CMD: one cycle, cas_rdy=1. Returns to CAS_WAIT if entries remain after the pop, otherwise to CAS_IDLE.
REQ-008 The head SHALL be eligible only when all of the following are 0: head rcd, gap_cnt, turn_cnt.
REQ-009 On entry to CAS_CMD the block SHALL pop the head and drive cas_req/cas_bg from it. It SHALL then load gap_cnt with the CCD window minus 1, where the window is tCCD_L if the next head's bg equals cas_bg and tCCD_S otherwise; with no next head it SHALL use tCCD_L.
REQ-010 A direction change is RD/RDA to WR/WRA, or the reverse; RD vs RDA and WR vs WRA are the same direction.
REQ-011 On a direction change at the head, turn_cnt SHALL be loaded once, with the window minus 1.
- Read-to-write window: RTW = CL - AL - CWL + BL/2 + 2.
- Write-to-read window: WTR = CWL + BL/2 + tWTR_L if same bg, otherwise tWTR_S.
- Arithmetic: CNT_W+2 bits; negative results clamp to 1.
REQ-012 The gap and turnaround windows SHALL both be enforced; the effective spacing is their maximum.
REQ-013 Latency: an isolated request pushed at cycle t into an idle queue SHALL produce cas_rdy at cycle t+tRCD. tRCD=0 or 1 SHALL issue at t+1.
REQ-014 Push and pop in the same cycle SHALL both take effect; q_full SHALL stay consistent.
REQ-015 Read/write pointers SHALL wrap modulo DEPTH.
REQ-016 The first CAS after reset or after CAS_IDLE SHALL see no turnaround; the last direction is cleared in idle.

Reset
REQ-017 While reset_n is low the block SHALL hold:
- state = CAS_IDLE
- queue empty
- all counters 0
- cas_rdy = 0, cas_req = 0, cas_bg = 0
- cas_idle = 1, q_full = 0, overflow = 0
REQ-018 A reset mid-operation SHALL discard all queued entries; no CAS SHALL issue until a new push arrives.

Structure
REQ-019 The request codes and the cas_sched_fsm_type enum SHALL live in ddr_pkg.
REQ-020 The FIFO SHALL be a sub-module cas_req_fifo, parametrised by DEPTH and entry width.
REQ-021 The turnaround-window calculation SHALL be a package function shared with other controller blocks.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- tRCD=14: single RD_R pushed at cycle 10 -> cas_rdy at cycle 24 with cas_req=RD_R; cas_idle returns to 1 at cycle 25.
- tRCD=4, tCCD_S=4, tCCD_L=6: RD bg0 then RD bg1 pushed on consecutive cycles -> CAS gap 4 cycles. Repeated with bg0, bg0 -> gap 6.
- CL=16, AL=0, CWL=12, BL=8: RD then WR, same bg -> WR issues 10 cycles after RD.
- CWL=12, BL=8, tWTR_L=8, tWTR_S=3: WR then RD -> same bg gap 24; different bg gap 19.
- DEPTH=8: nine pushes back-to-back with tRCD=20 -> eighth sets q_full, ninth sets overflow, exactly eight CAS issue in order.
- Reset asserted with 3 queued entries -> no cas_rdy until the next push; cas_idle=1 immediately.
